// File: rtl/snake_move_scheduler.sv
// Snake head move sequencer: turns keypad direction codes into a fixed-rate stream of steps,
// buffering up to two direction changes between steps and rejecting reversals.
module snake_move_scheduler #(
    parameter int unsigned PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          key_in,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    output logic                step,
    output logic [2:0]          dir,
    output logic [1:0]          dx,
    output logic [1:0]          dy,
    output logic [1:0]          pending
);

    typedef enum logic [1:0] {StIdle, StRun, StStep} state_e;

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [7:0]          key_prev_q;
    logic [2:0]          dir_q, dir_d;
    logic [2:0]          slot0_q, slot0_d;
    logic [2:0]          slot1_q, slot1_d;
    logic [1:0]          count_q, count_d;

    logic                key_valid;
    logic [2:0]          key_dir;
    logic [2:0]          ref_dir;
    logic [PERIOD_W-1:0] reload;
    logic                step_edge;
    logic                pop;
    logic                push;
    logic [1:0]          level_after_pop;

    always_comb begin
        key_valid = 1'b1;
        key_dir   = 3'd0;
        case (key_in)
            8'h38:   key_dir = 3'd0;
            8'h39:   key_dir = 3'd1;
            8'h36:   key_dir = 3'd2;
            8'h33:   key_dir = 3'd3;
            8'h32:   key_dir = 3'd4;
            8'h31:   key_dir = 3'd5;
            8'h34:   key_dir = 3'd6;
            8'h37:   key_dir = 3'd7;
            default: key_valid = 1'b0;
        endcase
    end

    // Periods below 2 behave as 2 so the STEP cycle always has a RUN cycle after it.
    assign reload    = (period < PERIOD_W'(2)) ? PERIOD_W'(1) : period - PERIOD_W'(1);
    assign step_edge = (state_q == StRun) && run && (cnt_q == '0);
    assign pop       = step_edge && (count_q != 2'd0);

    // New keys are judged against the newest queued direction, not the committed one.
    always_comb begin
        ref_dir = dir_q;
        if (count_q == 2'd2) begin
            ref_dir = slot1_q;
        end else if (count_q == 2'd1) begin
            ref_dir = slot0_q;
        end
    end

    assign level_after_pop = count_q - {1'b0, pop};
    assign push = key_valid && (key_in != key_prev_q) && (key_dir != ref_dir) &&
                  (key_dir != (ref_dir + 3'd4)) && (level_after_pop != 2'd2);

    always_comb begin
        dir_d   = dir_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = level_after_pop;
        if (pop) begin
            dir_d   = slot0_q;
            slot0_d = slot1_q;
        end
        if (push) begin
            if (level_after_pop == 2'd0) begin
                slot0_d = key_dir;
            end else begin
                slot1_d = key_dir;
            end
            count_d = level_after_pop + 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!run) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StRun;
                    cnt_d   = reload;
                end
                StRun: begin
                    if (cnt_q == '0) begin
                        state_d = StStep;
                        cnt_d   = reload;
                    end else begin
                        cnt_d = cnt_q - PERIOD_W'(1);
                    end
                end
                StStep: begin
                    state_d = StRun;
                    cnt_d   = cnt_q - PERIOD_W'(1);
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            key_prev_q <= 8'h34;
            dir_q      <= 3'd6;
            slot0_q    <= 3'd0;
            slot1_q    <= 3'd0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_prev_q <= key_in;
            dir_q      <= dir_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        dx = 2'b00;
        dy = 2'b00;
        case (dir_q)
            3'd0: begin dx = 2'b00; dy = 2'b11; end
            3'd1: begin dx = 2'b01; dy = 2'b11; end
            3'd2: begin dx = 2'b01; dy = 2'b00; end
            3'd3: begin dx = 2'b01; dy = 2'b01; end
            3'd4: begin dx = 2'b00; dy = 2'b01; end
            3'd5: begin dx = 2'b11; dy = 2'b01; end
            3'd6: begin dx = 2'b11; dy = 2'b00; end
            default: begin dx = 2'b11; dy = 2'b11; end
        endcase
    end

    assign step    = (state_q == StStep);
    assign dir     = dir_q;
    assign pending = count_q;

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Scoreboard bench for snake_move_scheduler: a time-based reference model predicts each cycle's
// step/pending and each step's move; a monitor compares them against the DUT on the falling edge.
module tb_snake_move_scheduler;

    localparam int unsigned PW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    key_in = 8'h34;
    logic          run = 1'b0;
    logic [PW-1:0] period = PW'(4);
    logic          step;
    logic [2:0]    dir;
    logic [1:0]    dx;
    logic [1:0]    dy;
    logic [1:0]    pending;

    snake_move_scheduler #(.PERIOD_W(PW)) dut (
        .clk     (clk),
        .rst     (rst),
        .key_in  (key_in),
        .run     (run),
        .period  (period),
        .step    (step),
        .dir     (dir),
        .dx      (dx),
        .dy      (dy),
        .pending (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic stp; logic [1:0] pend;} stat_t;
    typedef struct packed {logic [2:0] d; logic [1:0] x; logic [1:0] y;} mv_t;

    int checks = 0;
    int failures = 0;
    stat_t stat_q[$];
    mv_t   mv_q[$];

    logic [7:0] codes [8] = '{8'h38, 8'h39, 8'h36, 8'h33, 8'h32, 8'h31, 8'h34, 8'h37};
    int dx_t [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int dy_t [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

    // Reference model: direction queue plus absolute edge time of the next step.
    int         mq[$];
    int         m_dir = 6;
    logic [7:0] m_kprev = 8'h34;
    bit         m_running = 0;
    longint     m_edge = 0;
    longint     m_next = 0;

    function automatic int code_dir(logic [7:0] k);
        for (int i = 0; i < 8; i++) if (k == codes[i]) return i;
        return -1;
    endfunction

    function automatic int eff(logic [PW-1:0] p);
        return (p < 2) ? 2 : int'(p);
    endfunction

    function automatic mv_t mv_of(int d);
        mv_t m;
        m.d = 3'(d);
        m.x = 2'(dx_t[d]);
        m.y = 2'(dy_t[d]);
        return m;
    endfunction

    // A direction that the model says will be accepted, with a code different from key_in.
    function automatic int pick_dir();
        int t = (mq.size() > 0) ? mq[$] : m_dir;
        for (int k = 1; k < 8; k++) begin
            int d = (t + k) % 8;
            if (d != (t + 4) % 8 && codes[d] != key_in) return d;
        end
        return -1;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            mq.delete();
            m_dir = 6;
            m_kprev = 8'h34;
            m_running = 0;
            stat_q.delete();
            mv_q.delete();
        end else begin
            int d, r;
            bit stp, pop_m, push_m;
            m_edge++;
            stp = 0;
            if (!run) begin
                m_running = 0;
            end else if (!m_running) begin
                m_running = 1;
                m_next = m_edge + eff(period);
            end else if (m_edge == m_next) begin
                stp = 1;
                m_next = m_edge + eff(period);
            end
            pop_m = stp && mq.size() > 0;
            d = code_dir(key_in);
            r = (mq.size() > 0) ? mq[$] : m_dir;
            push_m = d >= 0 && key_in != m_kprev && d != r && d != (r + 4) % 8 &&
                     (mq.size() - int'(pop_m)) < 2;
            if (pop_m) m_dir = mq.pop_front();
            if (push_m) mq.push_back(d);
            m_kprev = key_in;
            stat_q.push_back({stp, 2'(mq.size())});
            if (stp) mv_q.push_back(mv_of(m_dir));
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            stat_t e;
            mv_t m;
            if (stat_q.size() == 0) begin
                check("status_queue_empty", 32'd1, 32'd0);
            end else begin
                e = stat_q.pop_front();
                check("step", {31'd0, step}, {31'd0, e.stp});
                check("pending", {30'd0, pending}, {30'd0, e.pend});
            end
            if (step === 1'b1) begin
                if (mv_q.size() == 0) begin
                    check("unexpected_step", 32'd1, 32'd0);
                end else begin
                    m = mv_q.pop_front();
                    check("move_dir_dx_dy", {25'd0, dir, dx, dy}, {25'd0, m});
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        tick(1);
    endtask

    task automatic push_key();
        int d = pick_dir();
        if (d < 0) check("pick_dir_found", 32'd0, 32'd1);
        else key_in = codes[d];
    endtask

    initial begin
        bit aligned;
        tick(3);
        check("reset_dir", {29'd0, dir}, 32'd6);
        check("reset_dx", {30'd0, dx}, 32'd3);
        check("reset_dy", {30'd0, dy}, 32'd0);
        check("reset_step", {31'd0, step}, 32'd0);
        check("reset_pending", {30'd0, pending}, 32'd0);

        // Free-running steps from reset release, period 4.
        run = 1'b1;
        release_reset();
        tick(14);

        // Two quick presses within one period.
        period = PW'(10);
        tick(12);
        key_in = 8'h38;
        tick(2);
        key_in = 8'h36;
        tick(2);
        tick(25);

        // Reversal rejection from a clean reset.
        key_in = 8'h34;
        rst = 1'b0;
        tick(2);
        release_reset();
        key_in = 8'h36;
        tick(2);
        check("reversal_dropped", {30'd0, pending}, 32'd0);
        key_in = 8'h38;
        tick(2);
        key_in = 8'h32;
        tick(2);
        check("reversal_of_queued", {30'd0, pending}, 32'd1);
        tick(20);

        // Overfill, then a push on the same edge as a pop with the queue full.
        key_in = 8'h38;
        tick(1);
        key_in = 8'h36;
        tick(1);
        key_in = 8'h33;
        tick(1);
        aligned = 0;
        for (int i = 0; i < 60 && !aligned; i++) begin
            if (mq.size() < 2) push_key();
            else if (m_running && run && m_edge + 1 == m_next) aligned = 1;
            if (!aligned) tick(1);
        end
        check("pop_edge_alignment", {31'd0, aligned}, 32'd1);
        push_key();
        tick(1);
        check("push_on_pop_full", {30'd0, pending}, 32'd2);
        tick(25);

        // Minimum period, then pause and resume.
        period = '0;
        tick(10);
        period = PW'(7);
        tick(10);
        run = 1'b0;
        push_key();
        tick(6);
        run = 1'b1;
        tick(20);

        // Reset while the queue is full.
        period = PW'(50);
        tick(55);
        for (int i = 0; i < 10 && mq.size() < 2; i++) begin
            push_key();
            tick(1);
        end
        check("full_before_reset", {30'd0, pending}, 32'd2);
        rst = 1'b0;
        #1;
        check("rst_pending", {30'd0, pending}, 32'd0);
        check("rst_step", {31'd0, step}, 32'd0);
        check("rst_dir", {29'd0, dir}, 32'd6);
        key_in = 8'h34;
        tick(2);
        release_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) key_in = 8'($urandom);
            else key_in = codes[$urandom_range(7)];
            run = ($urandom_range(15) != 0);
            if ($urandom_range(19) == 0) period = PW'($urandom_range(6));
            tick(1);
        end

        run = 1'b0;
        tick(3);
        check("moves_drained", mv_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
